// File: rtl/bip_pkg.sv
// Shared constants, opcode and fetch-state types for the BIP2 core.
package bip_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 16;
    localparam int unsigned ADDRESS_WIDTH     = 11;
    localparam int unsigned OPCODE_WIDTH      = INSTRUCTION_WIDTH - ADDRESS_WIDTH;

    // Only HLT matters to fetch; decode owns the rest of the opcode map.
    typedef enum logic [OPCODE_WIDTH-1:0] {
        HLT = 5'b00000
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]  opcode;
        logic [ADDRESS_WIDTH-1:0] operand;
    } instruction_t;

    function automatic logic is_halt(input instruction_t word);
        return word.opcode == HLT;
    endfunction

endpackage

// File: rtl/bip_program_counter.sv
// Program counter register: load has priority over increment, otherwise hold.
module bip_program_counter
    import bip_pkg::*;
(
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     load_in,
    input  logic [ADDRESS_WIDTH-1:0] load_value_in,
    input  logic                     increment_in,
    output logic [ADDRESS_WIDTH-1:0] pc_out
);

    // Increment wraps modulo 2^ADDRESS_WIDTH by construction.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            pc_out <= '0;
        end else if (load_in) begin
            pc_out <= load_value_in;
        end else if (increment_in) begin
            pc_out <= pc_out + ADDRESS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bip_fetch_unit.sv
// BIP2 instruction fetch: PC, instruction register, stall/branch/halt control.
// Optional HLT detection and HALT state enabled by BIP_FETCH_HALT_DETECT_EN.
module bip_fetch_unit
    import bip_pkg::*;
(
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         stall_in,
    input  logic                         branch_in,
    input  logic [ADDRESS_WIDTH-1:0]     branch_address_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
    output logic [ADDRESS_WIDTH-1:0]     address_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [OPCODE_WIDTH-1:0]      opcode_out,
    output logic [ADDRESS_WIDTH-1:0]     operand_out,
    output logic                         valid_out,
    output logic                         halted_out
);

    fetch_state_t             state;
    instruction_t             ir;
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     fetch_c;
    logic                     halt_hit_c;
    logic                     pc_load_c;
    logic                     pc_inc_c;

    // Branch beats stall; a detected HLT is captured but does not advance pc.
    always_comb begin
        fetch_c   = (state == RUN) && !branch_in && !stall_in;
        pc_load_c = (state == RUN) && branch_in;
`ifdef BIP_FETCH_HALT_DETECT_EN
        halt_hit_c = is_halt(instruction_t'(instruction_in));
`else
        halt_hit_c = 1'b0;
`endif
        pc_inc_c  = fetch_c && !halt_hit_c;
    end

    bip_program_counter u_pc (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .load_in       (pc_load_c),
        .load_value_in (branch_address_in),
        .increment_in  (pc_inc_c),
        .pc_out        (pc)
    );

`ifdef BIP_FETCH_HALT_DETECT_EN
    logic halted;
`endif

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
            ir    <= '0;
            valid <= 1'b0;
`ifdef BIP_FETCH_HALT_DETECT_EN
            halted <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= RUN;
                    valid <= 1'b0;
                end
                RUN: begin
                    if (branch_in) begin
                        valid <= 1'b0;
                    end else if (!stall_in) begin
                        ir    <= instruction_t'(instruction_in);
                        valid <= 1'b1;
`ifdef BIP_FETCH_HALT_DETECT_EN
                        if (halt_hit_c) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
`endif
                    end
                end
                HALT: begin
                    valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign address_out     = pc;
    assign instruction_out = ir;
    assign opcode_out      = ir.opcode;
    assign operand_out     = ir.operand;
    assign valid_out       = valid;
`ifdef BIP_FETCH_HALT_DETECT_EN
    assign halted_out      = halted;
`else
    assign halted_out      = 1'b0;
`endif

endmodule

// File: tb/tb_bip_fetch_unit.sv
// Self-checking bench for bip_fetch_unit: directed table, corner sequences, random vs reference model.
module tb_bip_fetch_unit;

`ifdef BIP_FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        stall_in = 1'b0;
    logic        branch_in = 1'b0;
    logic [10:0] branch_address_in = '0;
    logic [15:0] instruction_in;
    logic [10:0] address_out;
    logic [15:0] instruction_out;
    logic [4:0]  opcode_out;
    logic [10:0] operand_out;
    logic        valid_out;
    logic        halted_out;

    logic        hlt_en = 1'b0;
    logic [10:0] hlt_at = '0;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic        m_started;
    logic        m_halted;
    logic [10:0] m_pc;
    logic [15:0] m_ir;
    logic        m_valid;

    always #5 clock_in = ~clock_in;

    bip_fetch_unit dut (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .stall_in          (stall_in),
        .branch_in         (branch_in),
        .branch_address_in (branch_address_in),
        .instruction_in    (instruction_in),
        .address_out       (address_out),
        .instruction_out   (instruction_out),
        .opcode_out        (opcode_out),
        .operand_out       (operand_out),
        .valid_out         (valid_out),
        .halted_out        (halted_out)
    );

    // Combinational instruction memory
    assign instruction_in = (hlt_en && address_out == hlt_at) ? 16'h0000 : {5'b00001, address_out};

    function automatic logic [15:0] mem_word(input logic [10:0] a);
        if (hlt_en && a == hlt_at) return 16'h0000;
        return {5'b00001, a};
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_pc      = '0;
        m_ir      = '0;
        m_valid   = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic br, input logic [10:0] ba);
        logic [15:0] w;
        if (m_halted) begin
            m_valid = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_valid   = 1'b0;
        end else if (br) begin
            m_pc    = ba;
            m_valid = 1'b0;
        end else if (!st) begin
            w       = mem_word(m_pc);
            m_ir    = w;
            m_valid = 1'b1;
            if (HALT_EN && w[15:11] == 5'b00000) m_halted = 1'b1;
            else m_pc = m_pc + 11'd1;
        end
    endtask

    task automatic check_out(input string nm, input logic [10:0] ea, input logic [15:0] ei,
                             input logic ev, input logic eh);
        logic [4:0]  eop;
        logic [10:0] eopd;
        eop  = ei[15:11];
        eopd = ei[10:0];
        tests++;
        if (address_out !== ea || instruction_out !== ei || valid_out !== ev || halted_out !== eh
            || opcode_out !== eop || operand_out !== eopd) begin
            fails++;
            $display("FAIL %s: got addr=%0d ir=%h op=%h opd=%h valid=%b halted=%b, want addr=%0d ir=%h valid=%b halted=%b",
                     nm, address_out, instruction_out, opcode_out, operand_out, valid_out, halted_out,
                     ea, ei, ev, eh);
        end
    endtask

    // Drive inputs, advance model and DUT one edge, then settle.
    task automatic step(input logic st, input logic br, input logic [10:0] ba);
        stall_in          = st;
        branch_in         = br;
        branch_address_in = ba;
        model_edge(st, br, ba);
        @(posedge clock_in);
        #1;
    endtask

    task automatic apply_reset(input string nm);
        reset_in  = 1'b0;
        stall_in  = 1'b0;
        branch_in = 1'b0;
        #2;
        check_out(nm, 11'd0, 16'h0000, 1'b0, 1'b0);
        model_reset();
        @(negedge clock_in);
        reset_in = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        branch;
        logic [10:0] baddr;
        logic [10:0] ea;
        logic [15:0] ei;
        logic        ev;
    } vec_t;

    vec_t vt[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // stall, branch, baddr, exp addr, exp IR, exp valid
        vt[0]  = '{1'b0, 1'b0, 11'd0,    11'd0,    16'h0000, 1'b0}; // IDLE settle
        vt[1]  = '{1'b0, 1'b0, 11'd0,    11'd1,    16'h0800, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 11'd0,    11'd2,    16'h0801, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 11'd0,    11'd3,    16'h0802, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 11'd0,    11'd4,    16'h0803, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 11'd0,    11'd4,    16'h0803, 1'b1}; // stall x3
        vt[6]  = '{1'b1, 1'b0, 11'd0,    11'd4,    16'h0803, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 11'd0,    11'd4,    16'h0803, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 11'd0,    11'd5,    16'h0804, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 11'd9,    11'd9,    16'h0804, 1'b0}; // branch beats stall
        vt[10] = '{1'b0, 1'b0, 11'd0,    11'd10,   16'h0809, 1'b1};
        vt[11] = '{1'b0, 1'b1, 11'd2047, 11'd2047, 16'h0809, 1'b0};
        vt[12] = '{1'b0, 1'b0, 11'd0,    11'd0,    16'h0FFF, 1'b1}; // wrap
        vt[13] = '{1'b0, 1'b0, 11'd0,    11'd1,    16'h0800, 1'b1};
        vt[14] = '{1'b0, 1'b1, 11'd1,    11'd1,    16'h0800, 1'b0}; // branch to current pc
        vt[15] = '{1'b0, 1'b0, 11'd0,    11'd2,    16'h0801, 1'b1};

        model_reset();
        #3;
        check_out("reset_state", 11'd0, 16'h0000, 1'b0, 1'b0);
        @(negedge clock_in);
        reset_in = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vt[i].stall, vt[i].branch, vt[i].baddr);
            check_out($sformatf("vec%0d", i), vt[i].ea, vt[i].ei, vt[i].ev, 1'b0);
        end

        // Mid-run asynchronous reset, then IDLE again and restart at 0
        step(1'b0, 1'b0, 11'd0);
        apply_reset("midrun_reset");
        step(1'b0, 1'b0, 11'd0);
        check_out("post_reset_idle", 11'd0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 11'd0);
        check_out("post_reset_first", 11'd1, 16'h0800, 1'b1, 1'b0);

        // HLT word at address 3
        hlt_en = 1'b1;
        hlt_at = 11'd3;
        apply_reset("hlt_reset");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 11'd0);
        check_out("hlt_pre", 11'd3, 16'h0802, 1'b1, 1'b0);
        step(1'b0, 1'b0, 11'd0);
        tests++;
        if (instruction_out !== 16'h0000 || valid_out !== 1'b1 || address_out !== (HALT_EN ? 11'd3 : 11'd4)) begin
            fails++;
            $display("FAIL hlt_fetch: got ir=%h valid=%b addr=%0d, want ir=0000 valid=1 addr=%0d",
                     instruction_out, valid_out, address_out, HALT_EN ? 3 : 4);
        end
        step(1'b0, 1'b1, 11'd9);
        if (HALT_EN) check_out("hlt_frozen", 11'd3, 16'h0000, 1'b0, 1'b1);
        else         check_out("hlt_branch", 11'd9, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 11'd20);
        if (HALT_EN) check_out("hlt_ignore", 11'd3, 16'h0000, 1'b0, 1'b1);
        else         check_out("hlt_branch2", 11'd20, 16'h0000, 1'b0, 1'b0);
        hlt_en = 1'b0;
        apply_reset("rand_reset");

        // Random stall/branch/reset against the reference model
        for (int n = 0; n < 400; n++) begin
            logic        st;
            logic        br;
            logic [10:0] ba;
            if ($urandom_range(0, 59) == 0) begin
                apply_reset($sformatf("rand_async_reset%0d", n));
            end else begin
                st = ($urandom_range(0, 3) == 0);
                br = ($urandom_range(0, 7) == 0);
                ba = 11'($urandom);
                step(st, br, ba);
                check_out($sformatf("rand%0d", n), m_pc, m_ir, m_valid, m_halted);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
